// File: rtl/bp_pkg.sv
// Shared constants, types and helpers for the branch predictor slice.
package bp_pkg;

  // Two-bit counter encodings; the MSB is the predicted direction.
  localparam logic [1:0] CtrStrongNt = 2'b00;
  localparam logic [1:0] CtrWeakNt   = 2'b01;
  localparam logic [1:0] CtrWeakT    = 2'b10;
  localparam logic [1:0] CtrStrongT  = 2'b11;

  localparam int unsigned IdxBitsDefault = 6;
  typedef logic [IdxBitsDefault-1:0] bp_idx_t;

  // Weakly-taken value for a counter of ctr_bits width (2..4).
  function automatic logic [3:0] weakly_taken(input int unsigned ctr_bits);
    return 4'(1 << (ctr_bits - 1));
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational saturating up/down counter next-state.
module bp_sat_counter #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken && (ctr != '1)) begin
      ctr_next = ctr + CTR_BITS'(1);
    end else if (!taken && (ctr != '0)) begin
      ctr_next = ctr - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare/bimodal direction predictor with a power-up table sweep.
// Define GSHARE_GHR_EN to enable the global history register and XOR hashing.
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_BITS  = 6,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned HIST_BITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  output logic                pred_out_valid,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken,
  output logic                init_busy
);

  localparam int unsigned         Entries = 2 ** IDX_BITS;
  localparam logic [IDX_BITS-1:0] LastIdx = IDX_BITS'(Entries - 1);
  localparam logic [CTR_BITS-1:0] InitVal = CTR_BITS'(weakly_taken(CTR_BITS));

  localparam logic StInit  = 1'b0;
  localparam logic StReady = 1'b1;

  logic                state_q, state_d;
  logic [IDX_BITS-1:0] sweep_q, sweep_d;
  logic                ready;
  logic [CTR_BITS-1:0] table_q [Entries];
  logic [IDX_BITS-1:0] lookup_idx;
  logic [CTR_BITS-1:0] upd_ctr_next;
  logic                out_valid_q;
  logic                taken_q;
  logic [IDX_BITS-1:0] idx_q;
  logic                unused_pc;

  assign ready     = (state_q == StReady);
  assign unused_pc = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

`ifdef GSHARE_GHR_EN
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [IDX_BITS-1:0]  ghr_ext;

  always_comb begin
    ghr_ext                = '0;
    ghr_ext[HIST_BITS-1:0] = ghr_q;
  end

  always_comb begin
    ghr_d = ghr_q;
    if (ready && upd_valid) begin
      ghr_d = (ghr_q << 1) | HIST_BITS'(upd_taken);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign lookup_idx = pred_pc[IDX_BITS+1:2] ^ ghr_ext;
`else
  logic [31:0] unused_hist;

  assign unused_hist = 32'(HIST_BITS);
  assign lookup_idx  = pred_pc[IDX_BITS+1:2];
`endif

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      StInit: begin
        sweep_d = sweep_q + IDX_BITS'(1);
        if (sweep_q == LastIdx) begin
          state_d = StReady;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StInit;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  bp_sat_counter #(
    .CTR_BITS(CTR_BITS)
  ) u_upd_ctr (
    .ctr     (table_q[upd_idx]),
    .taken   (upd_taken),
    .ctr_next(upd_ctr_next)
  );

  // No reset on the array: the sweep rewrites every entry before READY.
  always_ff @(posedge clk) begin
    if (!ready) begin
      table_q[sweep_q] <= InitVal;
    end else if (upd_valid) begin
      table_q[upd_idx] <= upd_ctr_next;
    end
  end

  // Lookup reads table_q before this edge's update lands, giving read-before-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      idx_q       <= '0;
    end else begin
      out_valid_q <= ready && pred_valid;
      if (ready && pred_valid) begin
        taken_q <= table_q[lookup_idx][CTR_BITS-1];
        idx_q   <= lookup_idx;
      end
    end
  end

  assign pred_out_valid = out_valid_q;
  assign pred_taken     = taken_q;
  assign pred_idx       = idx_q;
  assign init_busy      = (state_q == StInit);

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench for gshare_branch_predictor at default parameters.
module tb_gshare_branch_predictor;
  import bp_pkg::*;

  logic        clk;
  logic        reset;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_out_valid;
  logic        pred_taken;
  bp_idx_t     pred_idx;
  logic        upd_valid;
  bp_idx_t     upd_idx;
  logic        upd_taken;
  logic        init_busy;

  gshare_branch_predictor #(
    .IDX_BITS (6),
    .CTR_BITS (2),
    .HIST_BITS(6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pred_valid    (pred_valid),
    .pred_pc       (pred_pc),
    .pred_out_valid(pred_out_valid),
    .pred_taken    (pred_taken),
    .pred_idx      (pred_idx),
    .upd_valid     (upd_valid),
    .upd_idx       (upd_idx),
    .upd_taken     (upd_taken),
    .init_busy     (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bp_idx_t idx;
    logic    taken;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] mdl_tbl[64];
  bp_idx_t    mdl_ghr;
  int         mdl_sweep;
  bit         mdl_ready;
  int         n_checks;
  int         n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bp_idx_t lookup(input logic [31:0] pc);
`ifdef GSHARE_GHR_EN
    return pc[7:2] ^ mdl_ghr;
`else
    return pc[7:2];
`endif
  endfunction

  // PC whose lookup lands on idx under the current model history.
  function automatic logic [31:0] pc_for(input bp_idx_t idx);
`ifdef GSHARE_GHR_EN
    return {24'h0, idx ^ mdl_ghr, 2'b00};
`else
    return {24'h0, idx, 2'b00};
`endif
  endfunction

  task automatic step(input logic pv, input logic [31:0] pc, input logic uv,
                      input bp_idx_t uidx, input logic ut);
    bit   pushed = 0;
    exp_t e;
    pred_valid = pv;
    pred_pc    = pc;
    upd_valid  = uv;
    upd_idx    = uidx;
    upd_taken  = ut;
    @(posedge clk);
    if (mdl_ready) begin
      if (pv) begin
        e.idx   = lookup(pc);
        e.taken = mdl_tbl[e.idx][1];
        exp_q.push_back(e);
        pushed = 1;
      end
      if (uv) begin
        if (ut && mdl_tbl[uidx] != 2'd3) mdl_tbl[uidx] = mdl_tbl[uidx] + 2'd1;
        else if (!ut && mdl_tbl[uidx] != 2'd0) mdl_tbl[uidx] = mdl_tbl[uidx] - 2'd1;
        mdl_ghr = {mdl_ghr[4:0], ut};
      end
    end else begin
      mdl_sweep++;
      if (mdl_sweep == 64) mdl_ready = 1;
    end
    #1;
    check("init_busy", init_busy, !mdl_ready);
    check("pred_out_valid", pred_out_valid, pushed);
    if (pred_out_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pred_idx", pred_idx, e.idx);
      check("pred_taken", pred_taken, e.taken);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    #3;
    check("rst_init_busy", init_busy, 1);
    check("rst_pred_out_valid", pred_out_valid, 0);
    check("rst_pred_taken", pred_taken, 0);
    check("rst_pred_idx", pred_idx, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mdl_sweep = 0;
    mdl_ready = 0;
    mdl_ghr   = '0;
    for (int i = 0; i < 64; i++) mdl_tbl[i] = CtrWeakT;
    exp_q.delete();
  endtask

  task automatic sweep_idle();
    for (int i = 0; i < 64; i++) step(1'b0, 32'h0, 1'b0, '0, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 64; i++) step(1'b1, pc_for(bp_idx_t'(i)), 1'b0, '0, 1'b0);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    pred_valid = 1'b0;
    pred_pc    = '0;
    upd_valid  = 1'b0;
    upd_idx    = '0;
    upd_taken  = 1'b0;
    do_reset();

    // Strobes held high through the sweep must be ignored.
    for (int i = 0; i < 64; i++) step(1'b1, 32'h0000_0104, 1'b1, 6'd9, 1'b1);
    step(1'b1, 32'h0000_0100, 1'b0, '0, 1'b0);
    read_all();

    // Saturation at both ends on index 5.
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 6'd5, 1'b1);
    step(1'b1, pc_for(6'd5), 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 6'd5, 1'b0);
    step(1'b1, pc_for(6'd5), 1'b0, '0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 6'd5, 1'b0);
    step(1'b1, pc_for(6'd5), 1'b0, '0, 1'b0);

    // Same-cycle predict/update of one entry: prediction sees the old counter.
    step(1'b0, 32'h0, 1'b1, 6'd5, 1'b1);
    step(1'b0, 32'h0, 1'b1, 6'd5, 1'b1);
    step(1'b1, pc_for(6'd5), 1'b1, 6'd5, 1'b0);
    step(1'b1, pc_for(6'd5), 1'b0, '0, 1'b0);

    // History hashing after two taken outcomes.
    do_reset();
    sweep_idle();
    step(1'b0, 32'h0, 1'b1, 6'd10, 1'b1);
    step(1'b0, 32'h0, 1'b1, 6'd10, 1'b1);
    step(1'b1, 32'h0, 1'b0, '0, 1'b0);
`ifdef GSHARE_GHR_EN
    check("ghr_hash_idx", pred_idx, 3);
`else
    check("bimodal_idx", pred_idx, 0);
`endif

    // Reset partway through the sweep restarts it.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, '0, 1'b0);
    do_reset();
    sweep_idle();
    read_all();

    // Random mix of predictions and updates.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           bp_idx_t'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gshare_branch_predictor.md
GSHARE_BRANCH_PREDICTOR -- requirements
Module: gshare_branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 6, log2 of pattern-table entries (2^IDX_BITS entries).
REQ-002 SHALL have parameter CTR_BITS, default 2, width of each saturating counter (2..4).
REQ-003 SHALL have parameter HIST_BITS, default 6, global history length (1..IDX_BITS).
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pred_valid  input  1  prediction request strobe.
REQ-007 SHALL have port pred_pc  input  32  branch address to predict.
REQ-008 SHALL have port pred_out_valid  output  1  prediction result valid.
REQ-009 SHALL have port pred_taken  output  1  predicted direction, 1 = taken.
REQ-010 SHALL have port pred_idx  output  IDX_BITS  table index used, returned by the pipeline on update.
REQ-011 SHALL have port upd_valid  input  1  resolved-branch update strobe.
REQ-012 SHALL have port upd_idx  input  IDX_BITS  index to train, the earlier pred_idx.
REQ-013 SHALL have port upd_taken  input  1  actual branch outcome.
REQ-014 SHALL have port init_busy  output  1  table initialisation sweep in progress.

Function
REQ-015 SHALL implement a two-state FSM: INIT (sweep) -> READY; reset forces INIT from any state.
REQ-016 In INIT, SHALL write one entry per cycle, ascending from index 0, to weakly-taken (2^(CTR_BITS-1)); after index 2^IDX_BITS-1 is written, SHALL move to READY on the next edge.
REQ-017 init_busy SHALL equal 1 exactly while in INIT; pred_valid and upd_valid SHALL be ignored in INIT (no output, no training, no history change).
REQ-018 Lookup index SHALL be pred_pc[IDX_BITS+1:2] XOR zero-extended GHR (macro enabled) or pred_pc[IDX_BITS+1:2] alone (macro disabled).
REQ-019 Prediction latency SHALL be one cycle: pred_valid at edge N -> pred_out_valid=1 for the cycle after N, with pred_taken = counter MSB and pred_idx = lookup index; pred_out_valid SHALL be 0 otherwise.
REQ-020 On upd_valid in READY, table[upd_idx] SHALL increment if upd_taken and below 2^CTR_BITS-1, decrement if !upd_taken and above 0, and otherwise hold (saturation).
REQ-021 On upd_valid in READY, GHR SHALL shift left by one with upd_taken entering bit 0; the oldest bit is discarded.
REQ-022 On same-cycle predict and update, including the same index, prediction SHALL use the pre-update counter and pre-update GHR (read-before-write); the update SHALL still complete.
REQ-023 Back-to-back pred_valid SHALL sustain one prediction per cycle; no stall and no ready signal.

Reset
REQ-024 On reset assertion: FSM=INIT, sweep pointer=0, GHR=0, pred_out_valid=0, pred_taken=0, pred_idx=0, init_busy=1.
REQ-025 Reset during the sweep or during operation SHALL restart the full sweep from index 0; init_busy stays high 2^IDX_BITS cycles after release.

Configuration
REQ-026 Macro GSHARE_GHR_EN defined SHALL instantiate the GHR and XOR hashing (gshare); undefined SHALL remove the GHR entirely and give pure bimodal PC indexing, with the interface unchanged.

Structure
REQ-027 Package bp_pkg SHALL hold the counter-state constants (strongly/weakly not-taken/taken for CTR_BITS=2), the weakly-taken init-value function and the index-width typedef.
REQ-028 Sub-module bp_sat_counter (combinational saturating next-state, parametrised by CTR_BITS) SHALL be used for the update path.

Verification (defaults IDX_BITS=6, CTR_BITS=2, HIST_BITS=6)
REQ-029 Reset pulse -> init_busy=1 for 64 cycles then 0; predict pc=0x100 -> pred_out_valid=1 next cycle, pred_taken=1.
REQ-030 Macro off: update idx 5 taken x3 -> counter 3; then not-taken x4 -> counter 0, predict idx 5 -> 0; 5th not-taken -> stays 0.
REQ-031 Predict and update of idx 5 (counter 2, not-taken) in the same cycle -> pred_taken=1; next predict of idx 5 -> 0.
REQ-032 Macro on, after updates taken,taken (GHR=6'b000011): predict pc=0x0 -> pred_idx=3; macro off -> pred_idx=0.
REQ-033 Reset reasserted 20 cycles into the sweep -> init_busy high a further 64 cycles after release; all entries read weakly-taken.
REQ-034 pred_valid and upd_valid held high during INIT -> pred_out_valid=0 throughout; GHR and table unchanged at READY.
